// File: rtl/n64_vinfo_ext_pkg.sv
// Shared types and constants for the N64 digital video front-end decoder.
// The packed struct below defines the vdata_pre slice layout.
package n64_vinfo_ext_pkg;

  localparam int COLOR_W = 7;
  localparam int VDATA_W = 3 * COLOR_W + 4;

  // Bit positions inside the 4-bit sync word
  localparam int SY_NVSYNC = 3;
  localparam int SY_NCLAMP = 2;
  localparam int SY_NHSYNC = 1;
  localparam int SY_NCSYNC = 0;

  typedef enum logic [1:0] {
    PH_SYNC = 2'b00,
    PH_RED  = 2'b01,
    PH_GRN  = 2'b10,
    PH_BLU  = 2'b11
  } phase_e;

  // {sync nibble, R, G, B}, MSB first
  typedef struct packed {
    logic [3:0]         sync;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } vdata_t;

endpackage

// File: rtl/n64_vinfo_ext_if.sv
// Pixel-bus interface: raw N64 video inputs plus the decoded, registered outputs.
interface n64_vinfo_ext_if;
  import n64_vinfo_ext_pkg::*;

  logic                 nDSYNC;
  logic [COLOR_W-1:0]   D_i;
  logic [VDATA_W-1:0]   vdata_pre;
  logic [1:0]           data_cnt;
  logic                 vmode;
  logic                 n64_480i;
  logic                 blurry_pixel_pos;
  logic                 dsync_err;

  modport master (
    output nDSYNC, D_i,
    input  vdata_pre, data_cnt, vmode, n64_480i, blurry_pixel_pos, dsync_err
  );

  modport slave (
    input  nDSYNC, D_i,
    output vdata_pre, data_cnt, vmode, n64_480i, blurry_pixel_pos, dsync_err
  );

endinterface

// File: rtl/n64_vinfo_ext_sync_meas.sv
// Frame measurement: counts lines between vertical syncs to pick PAL/NTSC,
// and tracks field-parity alternation to detect interlaced 480i.
module n64_sync_meas #(
  parameter int PAL_LINE_TH  = 288,
  parameter int I480_CONFIRM = 2
) (
  input  logic nCLK,
  input  logic nRST,
  input  logic vs_fall_i,
  input  logic hs_fall_i,
  input  logic parity_i,
  output logic vmode_o,
  output logic n64_480i_o
);

  localparam int               ALT_W   = $clog2(I480_CONFIRM + 1);
  localparam logic [ALT_W-1:0] ALT_MAX = ALT_W'(I480_CONFIRM);
  localparam logic [9:0]       LINE_TH = 10'(PAL_LINE_TH);

  logic [9:0]       line_q, line_d;
  logic [ALT_W-1:0] alt_q, alt_d;
  logic             last_par_q, last_par_d;
  logic             par_valid_q, par_valid_d;
  logic             vmode_q, vmode_d;
  logic             i480_q, i480_d;
  logic [ALT_W-1:0] alt_next;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    line_d      = line_q;
    alt_d       = alt_q;
    last_par_d  = last_par_q;
    par_valid_d = par_valid_q;
    vmode_d     = vmode_q;
    i480_d      = i480_q;

    alt_next = '0;
    if (par_valid_q && (parity_i != last_par_q)) begin
      alt_next = (alt_q == ALT_MAX) ? alt_q : alt_q + 1'b1;
    end

    // A vertical sync closes the frame; a coincident hsync edge is not counted
    if (vs_fall_i) begin
      vmode_d     = (line_q >= LINE_TH);
      line_d      = '0;
      alt_d       = alt_next;
      last_par_d  = parity_i;
      par_valid_d = 1'b1;
      i480_d      = (alt_next >= ALT_MAX);
    end else if (hs_fall_i && (line_q != 10'h3FF)) begin
      line_d = line_q + 10'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(negedge nCLK or negedge nRST) begin
    if (!nRST) begin
      line_q      <= '0;
      alt_q       <= '0;
      last_par_q  <= 1'b0;
      par_valid_q <= 1'b0;
      vmode_q     <= 1'b0;
      i480_q      <= 1'b0;
    end else begin
      line_q      <= line_d;
      alt_q       <= alt_d;
      last_par_q  <= last_par_d;
      par_valid_q <= par_valid_d;
      vmode_q     <= vmode_d;
      i480_q      <= i480_d;
    end
  end

  assign vmode_o    = vmode_q;
  assign n64_480i_o = i480_q;

endmodule

// File: rtl/n64_vinfo_ext.sv
// N64 digital video front-end: frames sync/R/G/B word groups on nDSYNC, keeps
// the previous group visible downstream, and derives frame-level mode info.
module n64_vinfo_ext
  import n64_vinfo_ext_pkg::*;
#(
  parameter int PAL_LINE_TH  = 288,
  parameter int I480_CONFIRM = 2
) (
  input  logic             nCLK,
  input  logic             nRST,
  n64_vinfo_ext_if.slave   bus
);

  phase_e cnt_q, cnt_d;
  vdata_t vdata_q, vdata_d;
  logic   blurry_q, blurry_d;
  logic   err_q, err_d;
  logic   sync_word;
  logic   vs_fall, hs_fall, hs_rise;

  assign sync_word = ~bus.nDSYNC;

  always_comb begin
    // Sync edges compare the incoming sync word against the one still held
    vs_fall = sync_word &  vdata_q.sync[SY_NVSYNC] & ~bus.D_i[SY_NVSYNC];
    hs_fall = sync_word &  vdata_q.sync[SY_NHSYNC] & ~bus.D_i[SY_NHSYNC];
    hs_rise = sync_word & ~vdata_q.sync[SY_NHSYNC] &  bus.D_i[SY_NHSYNC];

    cnt_d    = sync_word ? PH_RED : phase_e'(cnt_q + 2'd1);
    vdata_d  = vdata_q;
    blurry_d = blurry_q;
    err_d    = err_q | (sync_word ? (cnt_q != PH_SYNC) : (cnt_q == PH_SYNC));

    if (sync_word) begin
      vdata_d.sync = bus.D_i[3:0];
      blurry_d     = hs_rise | ~blurry_q;
    end else begin
      unique case (cnt_q)
        PH_RED:  vdata_d.r = bus.D_i;
        PH_GRN:  vdata_d.g = bus.D_i;
        PH_BLU:  vdata_d.b = bus.D_i;
        default: ;
      endcase
    end
  end

  // NOTE: the asynchronous reset forces every flop, including the data slices, so a mid-frame reset leaves no stale pixel data.
  always_ff @(negedge nCLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q    <= PH_SYNC;
      vdata_q  <= '{sync: 4'hF, r: '0, g: '0, b: '0};
      blurry_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      vdata_q  <= vdata_d;
      blurry_q <= blurry_d;
      err_q    <= err_d;
    end
  end

  n64_sync_meas #(
    .PAL_LINE_TH  (PAL_LINE_TH),
    .I480_CONFIRM (I480_CONFIRM)
  ) u_sync_meas (
    .nCLK       (nCLK),
    .nRST       (nRST),
    .vs_fall_i  (vs_fall),
    .hs_fall_i  (hs_fall),
    .parity_i   (bus.D_i[SY_NHSYNC]),
    .vmode_o    (bus.vmode),
    .n64_480i_o (bus.n64_480i)
  );

  assign bus.vdata_pre        = vdata_q;
  assign bus.data_cnt         = cnt_q;
  assign bus.blurry_pixel_pos = blurry_q;
  assign bus.dsync_err        = err_q;

endmodule

// File: doc/n64_vinfo_ext.md
Name: n64_vinfo_ext

Overview:
- Front-end decoder for the N64 digital video bus. It is the stage directly upstream of the de-blur estimator and the colour/blanking pipeline.
- Frames the 4-word pixel groups (sync, R, G, B) using nDSYNC.
- Builds the previous-group vector vdata_pre and the phase counter data_cnt.
- Derives frame-level info: vmode (PAL/NTSC), n64_480i, and the per-pixel blurry_pixel_pos toggle.

Parameters:
- COLOR_W, 7, width of one colour word on D_i.
- PAL_LINE_TH, 288, line count per frame at or above which vmode=1 (PAL).
- I480_CONFIRM, 2, number of consecutive field-parity alternations needed to assert n64_480i.

Ports:
- nCLK  in  1  pixel-bus clock; all state updates on its falling edge.
- nRST  in  1  asynchronous, active-low reset.
- nDSYNC  in  1  low marks the sync word of a group.
- D_i  in  COLOR_W  raw N64 data bus.
- vdata_pre  out  3*COLOR_W+4  previous words.
  - [3W+3:3W] = {nVSYNC, nCLAMP, nHSYNC, nCSYNC}.
  - [3W-1:2W] = R, [2W-1:W] = G, [W-1:0] = B.
- data_cnt  out  2  phase of current word: 00 sync, 01 R, 10 G, 11 B.
- vmode  out  1  1 = PAL, 0 = NTSC.
- n64_480i  out  1  1 = interlaced 480i detected.
- blurry_pixel_pos  out  1  toggles once per pixel group.
- dsync_err  out  1  sticky framing-error flag.

Behaviour:
- Reset: asynchronous on nRST low; all registers forced while low.
  - vdata_pre sync nibble = 4'hF; colour slices = 0.
  - data_cnt=00, vmode=0, n64_480i=0, blurry_pixel_pos=1, dsync_err=0.
  - Internal: line_cnt=0, alt_cnt=0, parity_valid=0.
  - Reset mid-frame discards all partial measurements.
- data_cnt:
  - Edge with nDSYNC low: data_cnt <= 01.
  - Otherwise: data_cnt <= data_cnt+1, wrapping 11->00.
  - A correct bus therefore shows 00 during every sync word.
- vdata_pre update: each slice is overwritten on the edge at which its new word is sampled, so at that edge the old value is still visible to downstream.
  - Sync slice <= D_i[3:0] when nDSYNC is low.
  - R slice <= D_i when nDSYNC is high and data_cnt=01.
  - G slice <= D_i when nDSYNC is high and data_cnt=10.
  - B slice <= D_i when nDSYNC is high and data_cnt=11.
  - Latency: 1 nCLK falling edge.
- Sync events, evaluated only on edges with nDSYNC low:
  - vs_fall = pre nVSYNC & ~D_i[3].
  - hs_fall = pre nHSYNC & ~D_i[1].
  - hs_rise = ~pre nHSYNC & D_i[1].
- line_cnt (10 bit):
  - +1 on hs_fall, saturating at 1023.
  - On vs_fall: evaluated first, then cleared to 0. If vs_fall and hs_fall coincide, the clear wins and that line is not counted.
- vmode: on vs_fall, vmode <= (line_cnt >= PAL_LINE_TH). Held between frames.
- n64_480i:
  - On vs_fall, parity = D_i[1].
  - If parity_valid and parity != last_parity: alt_cnt <= min(alt_cnt+1, I480_CONFIRM).
  - Otherwise alt_cnt <= 0.
  - Then last_parity <= parity, parity_valid <= 1, and n64_480i <= (next alt_cnt >= I480_CONFIRM).
  - A single non-alternating frame drops n64_480i on that same vs_fall.
- blurry_pixel_pos: on each nDSYNC-low edge, set to 1 if hs_rise, else toggled. Constant between sync words.
- dsync_err is set (sticky until nRST) when either:
  - nDSYNC is low while data_cnt != 00 (early sync), or
  - nDSYNC is high while data_cnt = 00 (missing sync).
  - Framing continues regardless of the error.
- Outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package/header, alongside the existing params include:
  - COLOR_W default.
  - vdata_pre slice macros (VDATA_SY/RE/GR/BL slices).
  - data_cnt phase constants.
  - Sync bit indices (nVSYNC=3, nCLAMP=2, nHSYNC=1, nCSYNC=0).
- One natural sub-module: n64_sync_meas, containing line_cnt, vmode and the 480i parity logic. It is fed by the vs_fall/hs_fall strobes and D_i[1].

Test Plan:
1. Reset release, then 10 well-formed groups (sync=F, R=01, G=02, B=03):
   - data_cnt cycles 00,01,10,11.
   - vdata_pre = {F,01,02,03} after the first full group.
   - dsync_err = 0.
2. NTSC 240p, 263 lines per frame, same nHSYNC level at every vs_fall, 4 frames -> vmode=0 and n64_480i=0 throughout.
3. PAL, 313 lines per frame -> vmode=1 from the first vs_fall after a full frame.
4. Alternating vs_fall parity (1,0,1,0):
   - n64_480i=1 at the 3rd vs_fall (2 alternations).
   - Injecting one repeated parity -> n64_480i=0 at that vs_fall.
5. hs_rise in a sync word -> blurry_pixel_pos=1, then 0,1,0 on the following sync words.
6. Framing and reset faults:
   - nDSYNC low at data_cnt=10 -> dsync_err=1 and data_cnt=01 on the next cycle; dsync_err stays 1.
   - nRST pulse mid-frame -> all outputs return to their reset values immediately, asynchronously.
